rr_queue_scheduler: RTL and testbench
=====================================

# rr_queue_scheduler

Four-requester buffered round-robin scheduler that shares one output channel between four byte streams. Each requester writes into its own private queue. A work-conserving rotating-priority scheduler drains the queues onto a single registered output port with a valid/ready handshake. Empty queues are skipped, so an idle requester costs no output bandwidth. The block sits between the four requester write ports and the shared downstream consumer.

## Interface
- DW, 8, data width of each requester and of dout
- DEPTH, 8, entries per queue; power of two, at least 2
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- wen  in  4  per-requester write strobe; bit i writes queue i
- a, b, c, d  in  DW each  write data for queues 0, 1, 2, 3
- full  out  4  queue i holds DEPTH entries (combinational from the count)
- drop  out  4  registered one-cycle pulse: the write to queue i in the previous cycle was discarded
- dout  out  DW  output data (registered)
- src  out  2  index of the queue dout came from (registered)
- valid  out  1  dout/src hold a word
- ready  in  1  consumer accepts the word this cycle

## Operation
- Queues: four independent circular buffers, each with write pointer, read pointer and a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Write: when wen[i]=1 and full[i]=0 at the clock edge, the data is stored and count[i] increments.
- Full write: when wen[i]=1 and full[i]=1, the data is discarded and drop[i]=1 for the next cycle. The write is dropped even if queue i is popped in the same cycle, because full is sampled before the edge.
- Output stage: a single register holding dout, src and valid.
  - The stage can load when valid=0, or when valid=1 and ready=1.
- Scheduler: when the stage can load, it searches for a non-empty queue.
  - Search order is ptr+1, ptr+2, ptr+3, ptr, all modulo 4, where ptr is the last granted index.
  - The first non-empty queue i found is granted.
  - On grant: queue i is popped, dout takes its head, src=i, valid=1, and ptr=i.
- No grant: if the stage can load but every queue is empty, valid=0 next cycle, dout/src hold their last values, and ptr is unchanged.
- Stall: valid=1 and ready=0 freezes dout, src, valid and ptr, and pops nothing.
- Fairness: with all four queues continuously non-empty and ready=1, grants repeat 0, 1, 2, 3, 0, …
  - One word per grant.
  - A requester waits at most 3 grants for service.
- Same-queue write and pop: allowed together on a non-full queue; count is unchanged.
  - No bypass: a word written into an empty queue becomes visible to the scheduler only after the edge that stores it.
- Reset (asserted at any time, including mid-transfer) asynchronously clears:
  - all counts and pointers, so all queues are empty and full=0;
  - valid=0, dout=0, src=0, drop=0;
  - ptr=3, so the first search starts at queue 0.
  - Queued data is lost. Nothing is popped or written while rst=1.

## Timing
- Write-to-output latency: a word written at edge k into an empty queue, with the output stage free and no competing queue, appears with valid=1 after edge k+1. That is 1 cycle of latency.
- Throughput: one word per cycle while ready=1 and any queue is non-empty.
- The grant decision is combinational from the counts, ptr, valid and ready. The outputs are registered.
- drop is asserted for exactly one cycle per discarded write, in the cycle after the offending edge.
- full changes in the cycle after the edge that changes the count.

## Test plan
- Reset: assert rst mid-stream with 5 words queued. Required: valid=0, dout=0, src=0, drop=0, full=0 immediately, without waiting for a clock edge. After release, the first grant goes to queue 0 if it is non-empty.
- Fairness: preload 3 words into each queue, then hold ready=1. Required: src sequence 0,1,2,3,0,1,2,3,0,1,2,3, with the data in per-queue FIFO order, then valid=0.
- Skipping: only queues 1 and 3 are loaded, with 2 words each. Required: src sequence 1,3,1,3 with no idle cycles between words.
- Overflow: write 9 words (0x01–0x09) to queue 2 with ready=0. Required: full[2]=1 after the 8th write, and drop[2] pulses once for 0x09. Draining then yields 0x01–0x08.
- Backpressure: hold ready=0 for 4 cycles while valid=1. Required: dout, src and ptr remain stable and counts do not decrease. Raising ready then resumes the sequence at the next queue.
- Simultaneous events: on a full queue, write and pop in the same cycle. Required: the write is dropped (drop pulses) and count becomes DEPTH-1. On a non-full queue, write and pop in the same cycle. Required: count is unchanged.

Source files
------------

// File: rtl/rr_queue_scheduler.sv
// Four private byte queues drained round-robin onto one registered
// valid/ready output port; empty queues are skipped (work conserving).
module rr_queue_scheduler #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    wen,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [3:0]    full,
  output logic [3:0]    drop,
  output logic [DW-1:0] dout,
  output logic [1:0]    src,
  output logic          valid,
  input  logic          ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] wdata [4];
  logic [DW-1:0] mem   [4][DEPTH];
  logic [AW-1:0] wptr  [4];
  logic [AW-1:0] rptr  [4];
  logic [CW-1:0] cnt   [4];

  logic [3:0]    empty;
  logic [3:0]    push;
  logic [3:0]    pop;
  logic [1:0]    ptr;
  logic          can_load;
  logic          gnt_vld;
  logic [1:0]    gnt_idx;
  logic [1:0]    cand;
  logic [DW-1:0] head;

  logic [DW-1:0] data_p1;
  logic [1:0]    src_p1;
  logic          vld_p1;

  assign wdata[0] = a;
  assign wdata[1] = b;
  assign wdata[2] = c;
  assign wdata[3] = d;

  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < 4; i++) begin
      full[i]  = (cnt[i] == FULL_CNT);
      empty[i] = (cnt[i] == '0);
    end
  end

  // Stage 0: rotating-priority search starting just after the last grant
  always_comb begin
    can_load = !vld_p1 || ready;
    gnt_vld  = 1'b0;
    gnt_idx  = ptr;
    cand     = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!gnt_vld && !empty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    pop = '0;
    if (can_load && gnt_vld) pop[gnt_idx] = 1'b1;
    push = wen & ~full;
    head = mem[gnt_idx][rptr[gnt_idx]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i] && !rst) mem[i][wptr[i]] <= wdata[i];
    end
  end

  // full is sampled before the edge, so a pop cannot rescue a write to a full queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
      drop <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
      drop <= wen & full;
    end
  end

  // Stage 1: registered output word, source index and grant pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      ptr     <= 2'd3;
    end else if (can_load) begin
      if (gnt_vld) begin
        vld_p1  <= 1'b1;
        data_p1 <= head;
        src_p1  <= gnt_idx;
        ptr     <= gnt_idx;
      end else begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign dout  = data_p1;
  assign src   = src_p1;
  assign valid = vld_p1;

endmodule

// File: tb/tb_rr_queue_scheduler.sv
// Directed bench for rr_queue_scheduler: reset, fairness, skipping,
// overflow, backpressure and simultaneous write/pop on one queue.
module tb_rr_queue_scheduler;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    wen;
  logic [DW-1:0] a, b, c, d;
  logic [3:0]    full, drop;
  logic [DW-1:0] dout;
  logic [1:0]    src;
  logic          valid;
  logic          ready;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rr_queue_scheduler #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wen(wen),
    .a(a), .b(b), .c(c), .d(d),
    .full(full), .drop(drop),
    .dout(dout), .src(src), .valid(valid), .ready(ready)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({valid, src, dout, drop, full} !== 19'd0) begin
      fails++;
      $display("FAIL reset_init: got v=%b s=%0d d=%h drop=%b full=%b want all zero", valid, src, dout, drop, full);
    end
    @(negedge clk);
    rst = 1'b0; ready = 1'b0;
    wen = 4'b0011; a = 8'h10; b = 8'h20; tick;
    a = 8'h11; b = 8'h21; tick;
    wen = 4'b0001; a = 8'h12; tick;
    wen = 4'b0000;
    checks++;
    if ({valid, src, dout} !== {1'b1, 2'd0, 8'h10}) begin
      fails++;
      $display("FAIL reset_prestream: got v=%b s=%0d d=%h want v=1 s=0 d=10", valid, src, dout);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({valid, src, dout, drop, full} !== 19'd0) begin
      fails++;
      $display("FAIL reset_async: got v=%b s=%0d d=%h drop=%b full=%b want all zero", valid, src, dout, drop, full);
    end
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    wen = 4'b0011; a = 8'h33; b = 8'h44; tick;
    wen = 4'b0000;
    checks++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_nobypass: got valid=%b want 0", valid);
    end
    tick;
    checks++;
    if ({valid, src, dout} !== {1'b1, 2'd0, 8'h33}) begin
      fails++;
      $display("FAIL reset_first_q0: got v=%b s=%0d d=%h want v=1 s=0 d=33", valid, src, dout);
    end
    tick;
    checks++;
    if ({valid, src, dout} !== {1'b1, 2'd1, 8'h44}) begin
      fails++;
      $display("FAIL reset_second_q1: got v=%b s=%0d d=%h want v=1 s=1 d=44", valid, src, dout);
    end
    tick;
    checks++;
    if ({valid, src, dout} !== {1'b0, 2'd1, 8'h44}) begin
      fails++;
      $display("FAIL reset_lost_data: got v=%b s=%0d d=%h want v=0 s=1 d=44", valid, src, dout);
    end
  endtask

  task automatic test_fairness;
    logic [7:0] base [4];
    logic [7:0] exp;
    base[0] = 8'hA0; base[1] = 8'hB0; base[2] = 8'hC0; base[3] = 8'hD0;
    ready = 1'b0;
    pulse_reset;
    for (int w = 0; w < 3; w++) begin
      wen = 4'b1111;
      a = base[0] + 8'(w); b = base[1] + 8'(w);
      c = base[2] + 8'(w); d = base[3] + 8'(w);
      tick;
    end
    wen = 4'b0000;
    for (int g = 0; g < 12; g++) begin
      if (g > 0) tick;
      exp = base[g % 4] + 8'(g / 4);
      checks++;
      if ({valid, src, dout} !== {1'b1, 2'(g % 4), exp}) begin
        fails++;
        $display("FAIL fair[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", g, valid, src, dout, g % 4, exp);
      end
      ready = 1'b1;
    end
    tick;
    checks++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL fair_idle: got valid=%b want 0", valid);
    end
  endtask

  task automatic test_skipping;
    logic [1:0] es [4];
    logic [7:0] ed [4];
    es[0] = 2'd1; es[1] = 2'd3; es[2] = 2'd1; es[3] = 2'd3;
    ed[0] = 8'h51; ed[1] = 8'h71; ed[2] = 8'h52; ed[3] = 8'h72;
    ready = 1'b1;
    wen = 4'b1010; b = 8'h51; d = 8'h71; tick;
    b = 8'h52; d = 8'h72; tick;
    wen = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick;
      checks++;
      if ({valid, src, dout} !== {1'b1, es[i], ed[i]}) begin
        fails++;
        $display("FAIL skip[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", i, valid, src, dout, es[i], ed[i]);
      end
    end
    tick;
    checks++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL skip_idle: got valid=%b want 0", valid);
    end
  endtask

  task automatic test_overflow;
    ready = 1'b0;
    wen = 4'b0001; a = 8'hEE; tick;
    for (int k = 1; k <= 9; k++) begin
      wen = 4'b0100; c = 8'(k); tick;
      if (k == 7) begin
        checks++;
        if (full !== 4'b0000) begin
          fails++;
          $display("FAIL ovf_full7: got full=%b want 0000", full);
        end
      end
      if (k == 8) begin
        checks++;
        if ({full, drop} !== {4'b0100, 4'b0000}) begin
          fails++;
          $display("FAIL ovf_full8: got full=%b drop=%b want full=0100 drop=0000", full, drop);
        end
      end
      if (k == 9) begin
        checks++;
        if ({full, drop} !== {4'b0100, 4'b0100}) begin
          fails++;
          $display("FAIL ovf_drop9: got full=%b drop=%b want full=0100 drop=0100", full, drop);
        end
      end
    end
    wen = 4'b0000; tick;
    checks++;
    if ({full, drop} !== {4'b0100, 4'b0000}) begin
      fails++;
      $display("FAIL ovf_drop_once: got full=%b drop=%b want full=0100 drop=0000", full, drop);
    end
    checks++;
    if ({valid, src, dout} !== {1'b1, 2'd0, 8'hEE}) begin
      fails++;
      $display("FAIL ovf_stall_word: got v=%b s=%0d d=%h want v=1 s=0 d=ee", valid, src, dout);
    end
    ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      checks++;
      if ({valid, src, dout} !== {1'b1, 2'd2, 8'(k)}) begin
        fails++;
        $display("FAIL ovf_drain[%0d]: got v=%b s=%0d d=%h want v=1 s=2 d=%h", k, valid, src, dout, 8'(k));
      end
    end
    tick;
    checks++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL ovf_idle: got valid=%b want 0", valid);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp;
    ready = 1'b0;
    pulse_reset;
    wen = 4'b1111; a = 8'h80; b = 8'h81; c = 8'h82; d = 8'h83; tick;
    a = 8'h90; b = 8'h91; c = 8'h92; d = 8'h93; tick;
    wen = 4'b0000;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) tick;
      checks++;
      if ({valid, src, dout} !== {1'b1, 2'd0, 8'h80}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%b s=%0d d=%h want v=1 s=0 d=80", s, valid, src, dout);
      end
    end
    ready = 1'b1;
    for (int j = 1; j < 8; j++) begin
      tick;
      exp = (j < 4) ? 8'h80 + 8'(j) : 8'h90 + 8'(j - 4);
      checks++;
      if ({valid, src, dout} !== {1'b1, 2'(j % 4), exp}) begin
        fails++;
        $display("FAIL bp_resume[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", j, valid, src, dout, j % 4, exp);
      end
    end
    tick;
    checks++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_idle: got valid=%b want 0", valid);
    end
  endtask

  task automatic test_simultaneous;
    logic [7:0] ed [8];
    for (int i = 0; i < 6; i++) ed[i] = 8'h13 + 8'(i);
    ed[6] = 8'hAB; ed[7] = 8'hAC;
    ready = 1'b0;
    pulse_reset;
    wen = 4'b0001; a = 8'h0A; tick;
    for (int k = 1; k <= 8; k++) begin
      wen = 4'b0010; b = 8'h10 + 8'(k); tick;
    end
    checks++;
    if (full !== 4'b0010) begin
      fails++;
      $display("FAIL sim_prefull: got full=%b want 0010", full);
    end
    wen = 4'b0010; b = 8'h99; ready = 1'b1; tick;
    checks++;
    if ({drop, full} !== {4'b0010, 4'b0000}) begin
      fails++;
      $display("FAIL sim_full_wp: got drop=%b full=%b want drop=0010 full=0000", drop, full);
    end
    checks++;
    if ({valid, src, dout} !== {1'b1, 2'd1, 8'h11}) begin
      fails++;
      $display("FAIL sim_full_pop: got v=%b s=%0d d=%h want v=1 s=1 d=11", valid, src, dout);
    end
    b = 8'hAB; tick;
    checks++;
    if ({drop, full, valid, src, dout} !== {4'b0000, 4'b0000, 1'b1, 2'd1, 8'h12}) begin
      fails++;
      $display("FAIL sim_wp: got drop=%b full=%b v=%b s=%0d d=%h want drop=0000 full=0000 v=1 s=1 d=12", drop, full, valid, src, dout);
    end
    ready = 1'b0; b = 8'hAC; tick;
    checks++;
    if ({drop, full, dout} !== {4'b0000, 4'b0010, 8'h12}) begin
      fails++;
      $display("FAIL sim_count7: got drop=%b full=%b d=%h want drop=0000 full=0010 d=12", drop, full, dout);
    end
    wen = 4'b0000; ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      checks++;
      if ({valid, src, dout} !== {1'b1, 2'd1, ed[i]}) begin
        fails++;
        $display("FAIL sim_drain[%0d]: got v=%b s=%0d d=%h want v=1 s=1 d=%h", i, valid, src, dout, ed[i]);
      end
    end
    tick;
    checks++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL sim_idle: got valid=%b want 0", valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    wen = 4'b0000;
    a = '0; b = '0; c = '0; d = '0;
    ready = 1'b0;
    test_reset;
    test_fairness;
    test_skipping;
    test_overflow;
    test_backpressure;
    test_simultaneous;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
